// File: rtl/axis_frame_src.sv
// AXI-Stream framed traffic generator: len-beat frames of incrementing data,
// k idle cycles between frames, run length set by num_frames or ended by stop.
module axis_frame_src #(
   parameter int Data_width = 8,
   parameter int Cnt_width  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [Data_width-1:0] seed,
   input  logic [Data_width-1:0] k,
   input  logic [Data_width-1:0] len,
   input  logic [Cnt_width-1:0]  num_frames,
   input  logic                  stop,
   output logic [Data_width-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic [Cnt_width-1:0]  frames_sent
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   localparam logic [Data_width-1:0] ONE_D = Data_width'(1);
   localparam logic [Cnt_width-1:0]  ONE_C = Cnt_width'(1);

   state_t                state, state_nxt;
   logic [Data_width-1:0] data_q;
   logic [Data_width-1:0] beat_cnt;
   logic [Data_width-1:0] gap_cnt;
   logic [Data_width-1:0] k_q;
   logic [Data_width-1:0] len_m1_q;
   logic [Cnt_width-1:0]  nf_q;
   logic                  stop_pend;
   logic                  last_q;

   logic xfer, beat_last, end_run, gap_end, stop_any;

   assign xfer      = (state == SEND) && m_ready;
   assign beat_last = (beat_cnt == len_m1_q);
   assign stop_any  = stop_pend || stop;
   assign end_run   = ((nf_q != '0) && ((frames_sent + ONE_C) == nf_q)) || stop_any;
   assign gap_end   = (gap_cnt == (k_q - ONE_D));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = SEND;
         SEND: if (xfer && beat_last)
                  state_nxt = end_run ? DONE : ((k_q != '0) ? GAP : SEND);
         GAP:  if (gap_end) state_nxt = stop_any ? DONE : SEND;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_valid = (state == SEND);
      m_last  = last_q && (state == SEND);
      m_data  = data_q;
      busy    = (state == SEND) || (state == GAP);
      done    = (state == DONE);
   end

   // Run configuration is only captured at start, so it needs no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         k_q      <= k;
         len_m1_q <= (len == '0) ? '0 : len - ONE_D;
         nf_q     <= num_frames;
      end
   end

   // last_q tracks the beat counter one step ahead so m_last is a flop output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q      <= '0;
         beat_cnt    <= '0;
         gap_cnt     <= '0;
         frames_sent <= '0;
         stop_pend   <= 1'b0;
         last_q      <= 1'b0;
      end else if (state == IDLE && start) begin
         data_q      <= seed;
         beat_cnt    <= '0;
         gap_cnt     <= '0;
         frames_sent <= '0;
         stop_pend   <= 1'b0;
         last_q      <= (len <= ONE_D);
      end else begin
         if (busy && stop) stop_pend <= 1'b1;
         if (state == DONE) stop_pend <= 1'b0;
         if (xfer) begin
            data_q <= data_q + ONE_D;
            if (beat_last) begin
               beat_cnt    <= '0;
               gap_cnt     <= '0;
               frames_sent <= frames_sent + ONE_C;
               last_q      <= (len_m1_q == '0);
            end else begin
               beat_cnt <= beat_cnt + ONE_D;
               last_q   <= ((beat_cnt + ONE_D) == len_m1_q);
            end
         end
         if (state == GAP) gap_cnt <= gap_cnt + ONE_D;
      end
   end

endmodule

// File: tb/tb_axis_frame_src.sv
// Scoreboard bench for axis_frame_src: expected beats are queued at start,
// popped on every observed transfer.
module tb_axis_frame_src;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] seed, k, len;
   logic [7:0] num_frames;
   logic       stop;
   logic [7:0] m_data;
   logic       m_valid, m_last, m_ready;
   logic       busy, done;
   logic [7:0] frames_sent;

   typedef struct {logic [7:0] d; logic l;} beat_t;
   beat_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0, vld_cyc = 0, gap_cyc = 0, last_cyc = 0, done_cyc = 0;
   logic       prev_v = 1'b0, prev_r = 1'b1, prev_l = 1'b0;
   logic [7:0] prev_d = '0;

   axis_frame_src #(.Data_width(8), .Cnt_width(8)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .k(k), .len(len),
      .num_frames(num_frames), .stop(stop), .m_data(m_data), .m_valid(m_valid),
      .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done),
      .frames_sent(frames_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Sampled on the falling edge: inputs only change just after rising edges.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (m_valid) vld_cyc = vld_cyc + 1;
      if (busy && !m_valid) gap_cyc = gap_cyc + 1;
      if (done) done_cyc = cyc;
      if (prev_v && !prev_r && rst) begin
         chk("stall_valid", m_valid, 1);
         chk("stall_data", m_data, prev_d);
         chk("stall_last", m_last, prev_l);
      end
      if (m_valid && m_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 0, 1);
         else begin
            beat_t e;
            e = sb.pop_front();
            chk("beat_data", m_data, e.d);
            chk("beat_last", m_last, e.l);
         end
         if (m_last) last_cyc = cyc;
      end
      prev_v = m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
   end

   task automatic start_run(input logic [7:0] s, input logic [7:0] kk, input logic [7:0] ll,
                            input logic [7:0] nf, input int push_frames);
      logic [7:0] d;
      int L;
      @(posedge clk); #1;
      seed = s; k = kk; len = ll; num_frames = nf; start = 1'b1;
      d = s;
      L = (ll == 0) ? 1 : int'(ll);
      for (int f = 0; f < push_frames; f++)
         for (int b = 0; b < L; b++) begin
            sb.push_back('{d, (b == L - 1)});
            d = d + 8'd1;
         end
      vld_cyc = 0; gap_cyc = 0;
      @(posedge clk); #1;
      start = 1'b0;
      seed = 8'($urandom); k = 8'($urandom); len = 8'($urandom); num_frames = 8'($urandom);
      chk("first_valid", m_valid, 1);
      chk("first_data", m_data, s);
   endtask

   task automatic wait_done(input int budget, input logic [7:0] exp_frames);
      bit got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk("done_seen", got, 1);
      chk("frames_sent", frames_sent, exp_frames);
      chk("sb_empty", sb.size(), 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
      chk("frames_hold", frames_sent, exp_frames);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; start = 1'b0; seed = '0; k = '0; len = '0; num_frames = '0;
      stop = 1'b0; m_ready = 1'b1;
      #12;
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_data", m_data, 0);
      chk("rst_frames", frames_sent, 0);
      @(posedge clk); #1 rst = 1'b1;

      // Basic run
      start_run(8'd1, 8'd1, 8'd8, 8'd4, 4);
      wait_done(100, 8'd4);
      chk("basic_gaps", gap_cyc, 3);
      chk("basic_beats", vld_cyc, 32);
      chk("basic_done_lat", done_cyc - last_cyc, 1);

      // Back-to-back with data wrap
      start_run(8'hFE, 8'd0, 8'd3, 8'd3, 3);
      wait_done(50, 8'd3);
      chk("b2b_gaps", gap_cyc, 0);
      chk("b2b_beats", vld_cyc, 9);

      // Backpressure on beat 2 of frame 1
      start_run(8'h30, 8'd2, 8'd4, 8'd2, 2);
      @(posedge clk); @(posedge clk); #1 m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 m_ready = 1'b1;
      wait_done(60, 8'd2);
      chk("bp_valid_cycles", vld_cyc, 11);

      // Continuous mode ended by stop during frame 3
      start_run(8'h50, 8'd1, 8'd5, 8'd0, 3);
      repeat (14) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      wait_done(60, 8'd3);

      // len=0 behaves as single-beat frames
      start_run(8'h10, 8'd0, 8'd0, 8'd3, 3);
      wait_done(30, 8'd3);
      chk("len0_beats", vld_cyc, 3);

      // Asynchronous reset during beat 3 of 8
      start_run(8'h40, 8'd0, 8'd8, 8'd1, 1);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_valid", m_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_frames", frames_sent, 0);
      chk("arst_last", m_last, 0);
      chk("arst_remaining", sb.size(), 5);
      sb.delete();
      @(posedge clk); #1 rst = 1'b1;
      start_run(8'h77, 8'd0, 8'd2, 8'd1, 1);
      wait_done(30, 8'd1);

      // start while busy is ignored
      start_run(8'h20, 8'd1, 8'd4, 8'd2, 2);
      repeat (2) @(posedge clk);
      #1 seed = 8'h99; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(60, 8'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_frame_src.md
Name: axis_frame_src

Overview:
- AXI-Stream master that generates framed test traffic for the stream FIFO's slave port.
- Frames are len beats long, with an incrementing data payload and m_last asserted on the final beat.
- The block inserts k idle cycles between frames and honours m_ready backpressure.
- It replaces hand-written initial-block stimulus, so FIFO benches and system integration get a synthesizable, repeatable traffic source.

Parameters:
- Data_width, 8, width of data beats and of the k/len configuration fields.
- Cnt_width, 8, width of the frame-count request and the frame-count status.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- start  input  1  one-cycle pulse; starts a run when the block is idle.
- seed  input  Data_width  first data value of the run.
- k  input  Data_width  idle cycles between frames.
- len  input  Data_width  beats per frame.
- num_frames  input  Cnt_width  frames per run; 0 means continuous.
- stop  input  1  requests the run to end at the next frame boundary.
- m_data  output  Data_width  stream data.
- m_valid  output  1  stream valid.
- m_last  output  1  final beat of the frame.
- m_ready  input  1  downstream ready.
- busy  output  1  a run is in progress.
- done  output  1  one-cycle pulse when the run completes.
- frames_sent  output  Cnt_width  frames completed in the current or last run.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - m_valid, m_last, busy, done are 0; m_data=0; frames_sent=0.
  - Reset mid-frame truncates the frame immediately. No m_last is emitted for it.
- Config latch: on start in IDLE, seed, k, len and num_frames are registered. Input changes during a run are ignored.
- len=0 is treated as len=1.
- Beat transfer occurs when m_valid and m_ready are both 1 on a rising edge.
- State IDLE:
  - m_valid=0, busy=0.
  - start moves to SEND on the next edge. Clear frames_sent, load data register with seed, set beat counter to 0.
  - start outside IDLE is ignored.
- State SEND:
  - m_valid=1 and busy=1.
  - m_data comes straight from the data register; m_last = (beat counter == len-1). Both are registered outputs.
  - The first beat appears 1 cycle after start.
  - On transfer: data register +1, wrapping modulo 2^Data_width, continuing across frame boundaries; beat counter +1.
  - On the last beat's transfer: frames_sent +1, beat counter cleared.
    - Next state is DONE if num_frames!=0 and frames_sent+1 == num_frames, or if stop is pending.
    - Otherwise GAP if k!=0, else SEND (back-to-back frames with no bubble).
- Handshake rules in SEND:
  - With m_ready=0, m_data, m_last and m_valid are held stable. m_valid never deasserts mid-frame.
  - m_valid is never conditioned on m_ready, to avoid a combinational loop.
- State GAP:
  - m_valid=0 for exactly k cycles, counted by a gap counter, then back to SEND.
  - Gap cycles are counted regardless of m_ready.
- State DONE: done=1 for one cycle, busy=0, then IDLE. frames_sent holds until the next start.
- stop:
  - Sampled any cycle while busy and held internally as pending.
  - Takes effect after the m_last transfer of the current frame; a frame is never truncated.
  - Pending stop during GAP goes to DONE at the end of the gap.
  - stop in IDLE is ignored.
  - stop coincident with the last-beat transfer goes to DONE.
- Continuous mode (num_frames=0): runs until stop. frames_sent wraps modulo 2^Cnt_width.
- Throughput: with m_ready held at 1, one frame occupies len+k cycles.

Test Plan:
- Basic run:
  - Stimulus: seed=1, len=8, k=1, num_frames=4, m_ready=1.
  - Required: 32 beats with data 1..32; m_last on data 8, 16, 24, 32; one idle cycle between frames; done pulses one cycle after the last beat; frames_sent=4.
- Back-to-back:
  - Stimulus: k=0, len=3, num_frames=3, seed=0xFE.
  - Required: m_valid high 9 consecutive cycles; data FE, FF, 00, 01, ..., 06 (wraps); m_last every 3rd beat.
- Backpressure:
  - Stimulus: len=4; drop m_ready for 3 cycles mid-frame at beat 2.
  - Required: m_data and m_last frozen during the stall; no beats lost or duplicated; total beats = 4 per frame.
- Stop and edge lengths:
  - Stimulus: num_frames=0, len=5; pulse stop at beat 2 of frame 3.
  - Required: frame 3 completes with m_last; done follows; frames_sent=3.
  - Stimulus: len=0 in a separate run. Required: 1-beat frames, m_last on every beat.
- Reset mid-frame:
  - Stimulus: assert rst=0 asynchronously during beat 3 of 8.
  - Required: m_valid falls before the next clock edge; busy=0, frames_sent=0.
  - After release with a new start, the first beat equals the new seed.
- Start ignored while busy:
  - Stimulus: pulse start with a different seed during a run.
  - Required: the sequence continues unchanged from the original seed; frames_sent is unaffected.
